multicycle_control_fsm: RTL

Sequencing controller for the multicycle RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal).
- Replaces the single-cycle main decoder with a Moore FSM driving the shared ALU, shared memory port and register/IR/PC write enables.
- Stretches memory states with a mem_ready wait handshake.
- Traps on unsupported opcodes.
- Reuses the team's existing ALUControl encoding.

---
 rtl/multicycle_control_fsm.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I-subset sequencing controller.
// Moore FSM driving the shared ALU, the shared memory port and the PC/IR/register
// write enables. Memory states stretch on mem_ready. Unsupported opcodes trap.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory responds
// DECODE   | read registers, branch/jump target into ALUOut
// MEMADR   | effective address for lw/sw
// MEMREAD  | load data read, waits for mem_ready
// MEMWB    | loaded data into rd
// MEMWRITE | store data written, waits for mem_ready
// EXECR    | R-type ALU op
// EXECI    | I-type ALU op
// ALUWB    | ALUOut into rd
// BEQ      | compare, take branch on Zero
// JAL      | PC <= target, link value computed
// TRAP     | unsupported opcode, held until reset
module multicycle_control_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     r_state;
    logic       w_ready;
    aluop_t     w_aluop;
    logic [2:0] w_funct_ctrl;

    // With waits disabled the memory is assumed to answer every cycle.
    assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state   = r_state;

    // State register and transitions; unused codes fall back to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXECR;
                        OP_I:         r_state <= S_EXECI;
                        OP_BEQ:       r_state <= S_BEQ;
                        OP_JAL:       r_state <= S_JAL;
                        default:      r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   r_state <= (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (w_ready) r_state <= S_MEMWB;
                S_MEMWRITE: if (w_ready) r_state <= S_FETCH;
                S_EXECR,
                S_EXECI,
                S_JAL:      r_state <= S_ALUWB;
                S_MEMWB,
                S_ALUWB,
                S_BEQ:      r_state <= S_FETCH;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // funct3/funct7 decode shared by R-type and I-type; sub only for R-type.
    always_comb begin
        w_funct_ctrl = 3'b000;
        case (funct3)
            3'b000:  w_funct_ctrl = (Op[5] & funct7) ? 3'b001 : 3'b000;
            3'b010:  w_funct_ctrl = 3'b101;
            3'b110:  w_funct_ctrl = 3'b011;
            3'b111:  w_funct_ctrl = 3'b010;
            default: w_funct_ctrl = 3'b000;
        endcase
    end

    // Moore output decode; reset holds every enable and select at zero.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = 3'b000;
        illegal    = 1'b0;
        w_aluop    = ALUOP_ADD;
        if (!reset) begin
            case (Op)
                OP_SW:   ImmSrc = 2'b01;
                OP_BEQ:  ImmSrc = 2'b10;
                OP_JAL:  ImmSrc = 2'b11;
                default: ImmSrc = 2'b00;
            endcase
            case (r_state)
                S_FETCH: begin
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = w_ready;
                    PCWrite   = w_ready;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    w_aluop = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    w_aluop = ALUOP_FUNCT;
                end
                S_ALUWB:    RegWrite = 1'b1;
                S_BEQ: begin
                    ALUSrcA = 2'b10;
                    w_aluop = ALUOP_SUB;
                    PCWrite = Zero;
                end
                S_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                S_TRAP:     illegal = 1'b1;
                default: ;
            endcase
            case (w_aluop)
                ALUOP_SUB:   ALUControl = 3'b001;
                ALUOP_FUNCT: ALUControl = w_funct_ctrl;
                default:     ALUControl = 3'b000;
            endcase
        end
    end

endmodule
